// File: rtl/prng_lanes.sv
// Multi-lane xorshift/rotate generator with warm-up discard, runtime reseed,
// a valid/ready output stage and optional range reduction of each lane word.
//
// state | meaning
// WARM  | all lanes step every cycle, outputs discarded, busy high
// RUN   | a word set loads into rng whenever the output slot is free or taken
module prng_lanes #(
    parameter int          LANES  = 4,
    parameter logic [31:0] SEED0  = 32'hFACEB00C,
    parameter logic [31:0] SEED1  = 32'hDEADBEEF,
    parameter int          ROT_A  = 19,
    parameter int          ROT_B  = 12,
    parameter int          SHL_C  = 8,
    parameter int          WARMUP = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  seed_we,
    input  logic [63:0]           seed_data,
    input  logic [31:0]           bound,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [LANES*32-1:0]   rng,
    output logic                  busy
);

    typedef enum logic {WARM, RUN} state_t;

    localparam state_t     START_STATE = (WARMUP > 0) ? WARM : RUN;
    localparam logic [7:0] WARM_LOAD   = 8'(WARMUP);

    state_t      state, state_nx;
    logic [7:0]  warm_cnt, warm_cnt_nx;
    logic        do_step, do_load;

    logic [31:0] s0     [LANES];
    logic [31:0] s1     [LANES];
    logic [31:0] s0_nx  [LANES];
    logic [31:0] s1_nx  [LANES];
    logic [31:0] s0_sd  [LANES];
    logic [31:0] s1_sd  [LANES];
    logic [31:0] xs     [LANES];
    logic [31:0] raw    [LANES];
    logic [LANES*32-1:0] words;
    logic [63:0] seed_src, seed_base;

    function automatic logic [31:0] rol(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    // Reset always reloads the default seeds; an all-zero pair would lock lane 0.
    always_comb begin
        seed_src  = reset ? {SEED0, SEED1} : seed_data;
        seed_base = (seed_src == 64'd0) ? {SEED0, SEED1} : seed_src;
        for (int i = 0; i < LANES; i++) begin
            s0_sd[i] = seed_base[63:32] ^ (32'(i) * 32'h9E3779B9);
            s1_sd[i] = seed_base[31:0]  ^ (32'(i) * 32'h7F4A7C15);
        end
    end

    always_comb begin
        words = '0;
        for (int i = 0; i < LANES; i++) begin
            xs[i]    = s0[i] ^ s1[i];
            s0_nx[i] = rol(xs[i], ROT_A);
            s1_nx[i] = rol(s0[i], ROT_B) ^ xs[i] ^ (xs[i] << SHL_C);
            raw[i]   = s0[i] + s1[i];
            if (bound == 32'd0)
                words[32*i +: 32] = raw[i];
            else
                words[32*i +: 32] = 32'(({32'd0, raw[i]} * {32'd0, bound}) >> 32);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= START_STATE;
            warm_cnt <= WARM_LOAD;
        end else begin
            state    <= state_nx;
            warm_cnt <= warm_cnt_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        warm_cnt_nx = warm_cnt;
        do_step     = 1'b0;
        do_load     = 1'b0;
        if (seed_we) begin
            state_nx    = START_STATE;
            warm_cnt_nx = WARM_LOAD;
        end else begin
            case (state)
                WARM: begin
                    do_step     = 1'b1;
                    warm_cnt_nx = warm_cnt - 8'd1;
                    if (warm_cnt <= 8'd1)
                        state_nx = RUN;
                end
                RUN: begin
                    if (!out_valid || out_ready) begin
                        do_load = 1'b1;
                        do_step = 1'b1;
                    end
                end
                default: state_nx = START_STATE;
            endcase
        end
    end

    // Reseed drops out_valid but keeps the last rng contents.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < LANES; i++) begin
                s0[i] <= s0_sd[i];
                s1[i] <= s1_sd[i];
            end
            out_valid <= 1'b0;
            rng       <= '0;
        end else if (seed_we) begin
            for (int i = 0; i < LANES; i++) begin
                s0[i] <= s0_sd[i];
                s1[i] <= s1_sd[i];
            end
            out_valid <= 1'b0;
        end else begin
            if (do_step) begin
                for (int i = 0; i < LANES; i++) begin
                    s0[i] <= s0_nx[i];
                    s1[i] <= s1_nx[i];
                end
            end
            if (do_load) begin
                rng       <= words;
                out_valid <= 1'b1;
            end
        end
    end

    assign busy = (state == WARM);

endmodule

// File: tb/tb_prng_lanes.sv
// Bench for prng_lanes: two instances (WARMUP 0 and 8) share stimulus and are
// compared against a word-stream reference model of the generator.
module tb_prng_lanes;

    localparam int L  = 4;
    localparam int NW = L * 32;
    typedef logic [NW-1:0] word_t;

    logic        clk = 1'b0;
    logic        reset, seed_we, out_ready;
    logic [63:0] seed_data;
    logic [31:0] bound;

    logic        ov_a, ov_b, bz_a, bz_b;
    word_t       rg_a, rg_b;
    logic        ov [2];
    logic        bz [2];
    word_t       rg [2];

    always #5 clk = ~clk;

    prng_lanes #(.LANES(L), .WARMUP(0)) dut_a (
        .clk(clk), .reset(reset), .seed_we(seed_we), .seed_data(seed_data),
        .bound(bound), .out_ready(out_ready), .out_valid(ov_a), .rng(rg_a), .busy(bz_a)
    );

    prng_lanes #(.LANES(L), .WARMUP(8)) dut_b (
        .clk(clk), .reset(reset), .seed_we(seed_we), .seed_data(seed_data),
        .bound(bound), .out_ready(out_ready), .out_valid(ov_b), .rng(rg_b), .busy(bz_b)
    );

    assign ov[0] = ov_a;
    assign ov[1] = ov_b;
    assign bz[0] = bz_a;
    assign bz[1] = bz_b;
    assign rg[0] = rg_a;
    assign rg[1] = rg_b;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input word_t obs, input word_t exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: per-instance lane states, advanced one word set at a time.
    logic [31:0] m_s0 [2][L];
    logic [31:0] m_s1 [2][L];
    int          warm_of [2] = '{0, 8};

    function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
        logic [63:0] d;
        d = {x, x} << n;
        return d[63:32];
    endfunction

    task automatic model_step(input int d);
        logic [31:0] a, b, xs;
        for (int i = 0; i < L; i++) begin
            a = m_s0[d][i];
            b = m_s1[d][i];
            xs = a ^ b;
            m_s0[d][i] = rotl(xs, 19);
            m_s1[d][i] = rotl(a, 12) ^ xs ^ (xs << 8);
        end
    endtask

    task automatic model_seed(input int d, input logic [63:0] sd);
        logic [63:0] s;
        s = (sd == 64'd0) ? {32'hFACEB00C, 32'hDEADBEEF} : sd;
        for (int i = 0; i < L; i++) begin
            m_s0[d][i] = s[63:32] ^ (32'(i) * 32'h9E3779B9);
            m_s1[d][i] = s[31:0]  ^ (32'(i) * 32'h7F4A7C15);
        end
        for (int k = 0; k < warm_of[d]; k++) model_step(d);
    endtask

    task automatic model_pop(input int d, output word_t w);
        longint unsigned r, prod;
        w = '0;
        for (int i = 0; i < L; i++) begin
            r = longint'(32'(m_s0[d][i] + m_s1[d][i]));
            if (bound == 32'd0) begin
                w[32*i +: 32] = 32'(r);
            end else begin
                prod = r * longint'(bound);
                w[32*i +: 32] = 32'(prod / 64'h1_0000_0000);
            end
        end
        model_step(d);
    endtask

    int    since [2];
    int    first_valid [2];
    int    busy_cnt [2];
    logic  stall [2];
    word_t held [2];
    int    viol = 0;
    int    words_a = 0;

    task automatic clear_track();
        for (int d = 0; d < 2; d++) begin
            since[d] = 0;
            first_valid[d] = -1;
            busy_cnt[d] = 0;
            stall[d] = 1'b0;
        end
    endtask

    // Called with next-edge inputs already driven, before that edge.
    task automatic sample_all();
        word_t w;
        for (int d = 0; d < 2; d++) begin
            if (stall[d]) check_eq(d == 0 ? "stall_hold_a" : "stall_hold_b", rg[d], held[d]);
            if (bz[d]) busy_cnt[d]++;
            if (ov[d] && first_valid[d] < 0) first_valid[d] = since[d];
            if (ov[d] && out_ready) begin
                model_pop(d, w);
                check_eq(d == 0 ? "word_a" : "word_b", rg[d], w);
                if (d == 0) words_a++;
                if (bound != 32'd0)
                    for (int i = 0; i < L; i++)
                        if (rg[d][32*i +: 32] >= bound) viol++;
            end
            stall[d] = ov[d] && !out_ready;
            held[d]  = rg[d];
            since[d]++;
        end
    endtask

    task automatic step_cycle();
        sample_all();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n, input int ready_pct);
        for (int k = 0; k < n; k++) begin
            out_ready = ($urandom_range(99) < ready_pct);
            step_cycle();
        end
    endtask

    task automatic do_reset(input logic [31:0] b, input logic with_seed);
        reset = 1'b1;
        seed_we = with_seed;
        seed_data = {$urandom, $urandom};
        bound = b;
        @(posedge clk);
        #1;
        check_eq("rst_valid_a", word_t'(ov_a), word_t'(0));
        check_eq("rst_valid_b", word_t'(ov_b), word_t'(0));
        check_eq("rst_rng_a", rg_a, '0);
        check_eq("rst_rng_b", rg_b, '0);
        check_eq("rst_busy_a", word_t'(bz_a), word_t'(0));
        check_eq("rst_busy_b", word_t'(bz_b), word_t'(1));
        @(posedge clk);
        #1;
        reset = 1'b0;
        seed_we = 1'b0;
        model_seed(0, 64'd0);
        model_seed(1, 64'd0);
        clear_track();
    endtask

    task automatic do_reseed(input logic [63:0] sd, input logic rdy);
        seed_we = 1'b1;
        seed_data = sd;
        out_ready = rdy;
        sample_all();
        @(posedge clk);
        #1;
        seed_we = 1'b0;
        model_seed(0, sd);
        model_seed(1, sd);
        clear_track();
        check_eq("reseed_valid_a", word_t'(ov_a), word_t'(0));
        check_eq("reseed_valid_b", word_t'(ov_b), word_t'(0));
        check_eq("reseed_busy_b", word_t'(bz_b), word_t'(1));
    endtask

    task automatic check_timing();
        check_eq("first_valid_a", word_t'(first_valid[0]), word_t'(1));
        check_eq("first_valid_b", word_t'(first_valid[1]), word_t'(9));
        check_eq("busy_cycles_a", word_t'(busy_cnt[0]), word_t'(0));
        check_eq("busy_cycles_b", word_t'(busy_cnt[1]), word_t'(8));
    endtask

    initial begin
        int guard;
        reset = 1'b1;
        seed_we = 1'b0;
        seed_data = 64'd0;
        bound = 32'd0;
        out_ready = 1'b1;
        clear_track();

        do_reset(32'd0, 1'b0);
        run(1, 100);
        check_eq("first_raw_a", word_t'(rg_a[31:0]), word_t'(32'hD97C6EFB));
        run(39, 100);
        check_timing();

        run(5, 0);
        run(20, 100);
        run(200, 60);

        check_eq("pre_reseed_valid_a", word_t'(ov_a), word_t'(1));
        do_reseed(64'd0, 1'b1);
        run(1, 100);
        check_eq("reseed0_first_a", word_t'(rg_a[31:0]), word_t'(32'hD97C6EFB));
        run(39, 100);
        check_timing();

        do_reseed({$urandom, $urandom}, 1'b1);
        run(300, 70);
        check_timing();

        do_reset(32'd2, 1'b0);
        run(1, 100);
        check_eq("bound2_first_a", word_t'(rg_a[31:0]), word_t'(32'd1));
        do_reset(32'h10000, 1'b0);
        run(1, 100);
        check_eq("bound64k_first_a", word_t'(rg_a[31:0]), word_t'(32'h0000D97C));

        do_reset(32'd7, 1'b0);
        words_a = 0;
        viol = 0;
        guard = 0;
        while (words_a < 10000 && guard < 20000) begin
            run(1, 88);
            guard++;
        end
        check_eq("range_words", word_t'(words_a >= 10000), word_t'(1));
        check_eq("range_below_bound", word_t'(viol), word_t'(0));

        do_reset(32'd0, 1'b0);
        run(12, 100);
        run(3, 0);
        do_reset(32'd0, 1'b1);
        run(1, 100);
        check_eq("rst_prio_first_a", word_t'(rg_a[31:0]), word_t'(32'hD97C6EFB));
        run(40, 80);
        check_timing();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
